reg_file_nxm: RTL and testbench

REG_FILE_NXM -- requirements
Module: reg_file_nxm

---
 rtl/reg_file_nxm.sv | 147 ++++++++++++++
 tb/tb_reg_file_nxm.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/reg_file_nxm.sv
// Dual-read, single-write register file with per-entry valid bits and a
// sequential bulk-clear engine that sweeps one entry per clock.
module reg_file_nxm #(
  parameter  int WIDTH = 4,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_enb_n,
  input  logic [AW-1:0]    wr_sel,
  input  logic [WIDTH-1:0] data_in,
  input  logic             rd_enb_n_a,
  input  logic [AW-1:0]    rd_sel_a,
  input  logic             rd_enb_n_b,
  input  logic [AW-1:0]    rd_sel_b,
  input  logic             clr,
  output logic [WIDTH-1:0] data_out_a,
  output logic             valid_a,
  output logic [WIDTH-1:0] data_out_b,
  output logic             valid_b,
  output logic             busy
);

  localparam logic [AW:0]      DEPTH_W  = (AW+1)'(DEPTH);
  localparam logic [AW-1:0]    LAST_IDX = AW'(DEPTH - 1);
  localparam logic [WIDTH-1:0] IDLE_BUS = {WIDTH{1'b1}};

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  state_t           state_r;
  state_t           state_nxt_s;
  logic [AW-1:0]    idx_r;
  logic             busy_r;
  logic [WIDTH-1:0] entry_r [DEPTH];
  logic [DEPTH-1:0] valid_r;
  logic             wr_acc_s;
  logic [WIDTH:0]   rd_a_s;
  logic [WIDTH:0]   rd_b_s;
  logic [WIDTH-1:0] data_out_a_r;
  logic [WIDTH-1:0] data_out_b_r;
  logic             valid_a_r;
  logic             valid_b_r;

  // Read lookup result as {valid, data}; an accepted write to the same address wins.
  function automatic logic [WIDTH:0] rd_lookup(input logic enb_n, input logic [AW-1:0] sel);
    logic [WIDTH:0] res;
    res = {1'b0, IDLE_BUS};
    if (enb_n || ({1'b0, sel} >= DEPTH_W)) begin
      res = {1'b0, IDLE_BUS};
    end else if (wr_acc_s && (wr_sel == sel)) begin
      res = {1'b1, data_in};
    end else if (valid_r[sel]) begin
      res = {1'b1, entry_r[sel]};
    end else begin
      res = {1'b0, IDLE_BUS};
    end
    return res;
  endfunction

  // Write qualification: only in IDLE, not alongside a clear request, in range.
  always_comb begin
    wr_acc_s = 1'b0;
    if (!wr_enb_n && (state_r == ST_IDLE) && !clr && ({1'b0, wr_sel} < DEPTH_W)) begin
      wr_acc_s = 1'b1;
    end else begin
      wr_acc_s = 1'b0;
    end
  end

  // Clear FSM next-state decode.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (clr) state_nxt_s = ST_CLEAR;
        else     state_nxt_s = ST_IDLE;
      end
      ST_CLEAR: begin
        if (idx_r == LAST_IDX) state_nxt_s = ST_IDLE;
        else                   state_nxt_s = ST_CLEAR;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Read port lookups for both ports.
  always_comb begin
    rd_a_s = rd_lookup(rd_enb_n_a, rd_sel_a);
    rd_b_s = rd_lookup(rd_enb_n_b, rd_sel_b);
  end

  // FSM state, sweep index and busy flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      idx_r   <= {AW{1'b0}};
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      busy_r  <= (state_nxt_s == ST_CLEAR);
      if ((state_r == ST_CLEAR) && (idx_r != LAST_IDX)) idx_r <= idx_r + AW'(1);
      else                                              idx_r <= {AW{1'b0}};
    end
  end

  // Storage array: the clear sweep has priority, writes are already blocked while busy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) entry_r[i] <= {WIDTH{1'b0}};
      valid_r <= {DEPTH{1'b0}};
    end else if (state_r == ST_CLEAR) begin
      entry_r[idx_r] <= {WIDTH{1'b0}};
      valid_r[idx_r] <= 1'b0;
    end else if (wr_acc_s) begin
      entry_r[wr_sel] <= data_in;
      valid_r[wr_sel] <= 1'b1;
    end else begin
      valid_r <= valid_r;
    end
  end

  // Registered read outputs; idle bus value is all ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out_a_r <= IDLE_BUS;
      valid_a_r    <= 1'b0;
      data_out_b_r <= IDLE_BUS;
      valid_b_r    <= 1'b0;
    end else begin
      data_out_a_r <= rd_a_s[WIDTH-1:0];
      valid_a_r    <= rd_a_s[WIDTH];
      data_out_b_r <= rd_b_s[WIDTH-1:0];
      valid_b_r    <= rd_b_s[WIDTH];
    end
  end

  assign data_out_a = data_out_a_r;
  assign valid_a    = valid_a_r;
  assign data_out_b = data_out_b_r;
  assign valid_b    = valid_b_r;
  assign busy       = busy_r;

endmodule

// File: tb/tb_reg_file_nxm.sv
// Scoreboard bench: two register files (4x4 and 5x8) share one stimulus stream
// and are compared against an array-based reference model.
module tb_reg_file_nxm;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       wr_enb_n = 1'b1;
  logic [2:0] wr_sel = 3'd0;
  logic [7:0] data_in = 8'h00;
  logic       rd_enb_n_a = 1'b1;
  logic [2:0] rd_sel_a = 3'd0;
  logic       rd_enb_n_b = 1'b1;
  logic [2:0] rd_sel_b = 3'd0;
  logic       clr = 1'b0;

  logic [3:0] dout_a0, dout_b0;
  logic [7:0] dout_a1, dout_b1;
  logic       va0, vb0, va1, vb1, busy0, busy1;

  typedef struct packed {
    logic [1:0][7:0] da;
    logic [1:0]      va;
    logic [1:0][7:0] db;
    logic [1:0]      vb;
    logic [1:0]      bz;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   failures = 0;

  logic [7:0] m_mem [2][64];
  bit         m_val [2][64];
  int         m_cnt [2];
  int         m_idx [2];
  int         dep   [2] = '{4, 5};
  logic [7:0] msk   [2] = '{8'h0F, 8'hFF};
  logic [2:0] smsk  [2] = '{3'b011, 3'b111};

  logic [1:0][7:0] act_da, act_db;
  logic [1:0]      act_va, act_vb, act_bz;
  assign act_da = {dout_a1, {4'h0, dout_a0}};
  assign act_db = {dout_b1, {4'h0, dout_b0}};
  assign act_va = {va1, va0};
  assign act_vb = {vb1, vb0};
  assign act_bz = {busy1, busy0};

  reg_file_nxm #(.WIDTH(4), .DEPTH(4)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .wr_enb_n(wr_enb_n), .wr_sel(wr_sel[1:0]),
    .data_in(data_in[3:0]), .rd_enb_n_a(rd_enb_n_a), .rd_sel_a(rd_sel_a[1:0]),
    .rd_enb_n_b(rd_enb_n_b), .rd_sel_b(rd_sel_b[1:0]), .clr(clr),
    .data_out_a(dout_a0), .valid_a(va0), .data_out_b(dout_b0), .valid_b(vb0), .busy(busy0)
  );

  reg_file_nxm #(.WIDTH(8), .DEPTH(5)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .wr_enb_n(wr_enb_n), .wr_sel(wr_sel),
    .data_in(data_in), .rd_enb_n_a(rd_enb_n_a), .rd_sel_a(rd_sel_a),
    .rd_enb_n_b(rd_enb_n_b), .rd_sel_b(rd_sel_b), .clr(clr),
    .data_out_a(dout_a1), .valid_a(va1), .data_out_b(dout_b1), .valid_b(vb1), .busy(busy1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic logic [8:0] rd_model(input int k, input logic en_n, input int s,
                                          input bit wr_ok, input int ws, input logic [7:0] d);
    if (en_n || s >= dep[k]) return {1'b0, msk[k]};
    if (wr_ok && ws == s)    return {1'b1, d};
    if (m_val[k][s])         return {1'b1, m_mem[k][s]};
    return {1'b0, msk[k]};
  endfunction

  // Reference behaviour of one rising edge for both instances.
  task automatic model_edge(output exp_t e);
    for (int k = 0; k < 2; k++) begin
      logic [7:0] d;
      logic [8:0] ra, rb;
      int ws, sa, sb;
      bit wr_ok;
      d  = data_in & msk[k];
      ws = int'(wr_sel & smsk[k]);
      sa = int'(rd_sel_a & smsk[k]);
      sb = int'(rd_sel_b & smsk[k]);
      wr_ok = !wr_enb_n && (m_cnt[k] == 0) && !clr && (ws < dep[k]);
      ra = rd_model(k, rd_enb_n_a, sa, wr_ok, ws, d);
      rb = rd_model(k, rd_enb_n_b, sb, wr_ok, ws, d);
      e.da[k] = ra[7:0]; e.va[k] = ra[8];
      e.db[k] = rb[7:0]; e.vb[k] = rb[8];
      if (m_cnt[k] > 0) begin
        m_mem[k][m_idx[k]] = 8'h00;
        m_val[k][m_idx[k]] = 1'b0;
        m_idx[k]++;
        m_cnt[k]--;
      end else if (clr) begin
        m_cnt[k] = dep[k];
        m_idx[k] = 0;
      end else if (wr_ok) begin
        m_mem[k][ws] = d;
        m_val[k][ws] = 1'b1;
      end
      e.bz[k] = (m_cnt[k] > 0);
    end
  endtask

  task automatic step(input logic wn, input logic [2:0] ws, input logic [7:0] d,
                      input logic an, input logic [2:0] sa, input logic bn,
                      input logic [2:0] sb, input logic c);
    exp_t e;
    wr_enb_n = wn; wr_sel = ws; data_in = d;
    rd_enb_n_a = an; rd_sel_a = sa; rd_enb_n_b = bn; rd_sel_b = sb; clr = c;
    model_edge(e);
    sb_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("rst_da%0d", k), act_da[k], msk[k]);
      chk($sformatf("rst_db%0d", k), act_db[k], msk[k]);
      chk($sformatf("rst_va%0d", k), {7'd0, act_va[k]}, 8'd0);
      chk($sformatf("rst_vb%0d", k), {7'd0, act_vb[k]}, 8'd0);
      chk($sformatf("rst_busy%0d", k), {7'd0, act_bz[k]}, 8'd0);
      m_cnt[k] = 0;
      m_idx[k] = 0;
      for (int i = 0; i < 64; i++) begin
        m_mem[k][i] = 8'h00;
        m_val[k][i] = 1'b0;
      end
    end
    wr_enb_n = 1'b1; rd_enb_n_a = 1'b1; rd_enb_n_b = 1'b1; clr = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: one registered response per edge, compared just after the edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("data_a%0d", k), act_da[k], e.da[k]);
        chk($sformatf("valid_a%0d", k), {7'd0, act_va[k]}, {7'd0, e.va[k]});
        chk($sformatf("data_b%0d", k), act_db[k], e.db[k]);
        chk($sformatf("valid_b%0d", k), {7'd0, act_vb[k]}, {7'd0, e.vb[k]});
        chk($sformatf("busy%0d", k), {7'd0, act_bz[k]}, {7'd0, e.bz[k]});
      end
    end
  end

  initial begin
    @(negedge clk);
    do_reset();
    // Default read, write then dual read, same-edge write-through.
    step(1'b1, 3'd0, 8'h00, 1'b0, 3'd2, 1'b1, 3'd0, 1'b0);
    step(1'b0, 3'd1, 8'hAA, 1'b1, 3'd0, 1'b1, 3'd0, 1'b0);
    step(1'b1, 3'd0, 8'h00, 1'b0, 3'd1, 1'b0, 3'd1, 1'b0);
    step(1'b0, 3'd3, 8'h55, 1'b0, 3'd3, 1'b0, 3'd1, 1'b0);
    // Out-of-range access on the 5-deep instance.
    step(1'b0, 3'd7, 8'h77, 1'b0, 3'd6, 1'b0, 3'd7, 1'b0);
    // Fill, clear with a colliding write, writes during busy, then sweep reads.
    for (int i = 0; i < 5; i++) step(1'b0, 3'(i), 8'(8'h31 + i), 1'b0, 3'(i), 1'b1, 3'd0, 1'b0);
    step(1'b0, 3'd0, 8'hC3, 1'b0, 3'd0, 1'b0, 3'd2, 1'b1);
    for (int i = 0; i < 6; i++) step(1'b0, 3'd0, 8'hE1, 1'b0, 3'(i), 1'b0, 3'd4, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b1, 3'd0, 8'h00, 1'b0, 3'(i), 1'b0, 3'(4 - i), 1'b0);
    // Reset during the second cycle of a clear, then a fresh write.
    step(1'b0, 3'd2, 8'h12, 1'b1, 3'd0, 1'b1, 3'd0, 1'b0);
    step(1'b1, 3'd0, 8'h00, 1'b1, 3'd0, 1'b1, 3'd0, 1'b1);
    step(1'b1, 3'd0, 8'h00, 1'b0, 3'd2, 1'b1, 3'd0, 1'b0);
    do_reset();
    step(1'b0, 3'd2, 8'h6B, 1'b0, 3'd2, 1'b0, 3'd0, 1'b0);
    step(1'b1, 3'd0, 8'h00, 1'b0, 3'd2, 1'b0, 3'd2, 1'b0);
    // Randomised traffic with occasional clears and resets.
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 249) == 0) do_reset();
      else step($urandom_range(0, 2) == 0, 3'($urandom_range(0, 7)), 8'($urandom),
                $urandom_range(0, 4) == 0, 3'($urandom_range(0, 7)),
                $urandom_range(0, 4) == 0, 3'($urandom_range(0, 7)),
                $urandom_range(0, 39) == 0);
    end
    repeat (3) @(negedge clk);
    chk("sb_drain", 8'(sb_q.size()), 8'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
